divisor_seq: RTL and testbench

DIVISOR_SEQ -- requirements
Module: divisor_seq

---
 rtl/divisor_seq.sv | 152 +++++++++++++++
 tb/tb_divisor_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
// Sequential 32-bit signed divider: restoring shift-subtract on magnitudes,
// one quotient bit per clock, sign correction in a final FIX cycle.
module divisor_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] out_high,
  output logic [31:0] out_low,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;

  assign abs_dividend = dividend[31] ? (32'd0 - dividend) : dividend;
  assign abs_divisor  = divisor[31]  ? (32'd0 - divisor)  : divisor;

  // Shift the next dividend bit into the partial remainder; a borrow in
  // bit 33 of the trial means the divisor does not fit this step.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {2'b00, dvs_q};

  assign quo_signed = (sign_a_q ^ sign_b_q) ? (32'd0 - quo_q) : quo_q;
  assign rem_signed = sign_a_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (divisor == 32'd0) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d  = RUN;
            rem_d    = 33'd0;
            quo_d    = abs_dividend;
            dvs_d    = abs_divisor;
            sign_a_d = dividend[31];
            sign_b_d = divisor[31];
            cnt_d    = 5'd31;
            dz_d     = 1'b0;
            busy_d   = 1'b1;
          end
        end
      end

      RUN: begin
        if (trial[33]) begin
          rem_d = shifted[32:0];
        end else begin
          rem_d = trial[32:0];
        end
        quo_d = {quo_q[30:0], ~trial[33]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d    = quo_signed;
        hi_d    = rem_signed;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign out_high = hi_q;
  assign out_low  = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed and randomized checks of divisor_seq against a 64-bit arithmetic
// reference for truncating signed division.
module tb_divisor_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd1;
  logic [31:0] out_high;
  logic [31:0] out_low;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  divisor_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .out_high (out_high),
    .out_low  (out_low),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division done in 64 bits, so the
  // most-negative / -1 case wraps naturally to 0x80000000.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sq = sa / sb;
    sr = sa - sq * sb;
    q = sq[31:0];
    r = sr[31:0];
  endfunction

  // Called #1 after an edge with the DUT idle; leaves start at 'hold'.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input string tag);
    logic [31:0] eq, er;
    int n;
    bit seen;
    ref_div(a, b, eq, er);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      if (!hold) start = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else if (n <= 32) chk($sformatf("%s_busy_e%0d", tag, n), {31'd0, busy}, 32'd1);
    end
    chk({tag, "_latency"}, n, 32'd33);
    chk({tag, "_lo"}, out_low, eq);
    chk({tag, "_hi"}, out_high, er);
    chk({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    last_hi = er;
    last_lo = eq;
    $display("op %s: %h / %h -> lo=%h hi=%h latency=%0d", tag, a, b, out_low, out_high, n);
  endtask

  task automatic run_zero(input logic [31:0] a, input string tag);
    dividend = a;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_dz"}, {31'd0, div_zero}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, out_high, last_hi);
    chk({tag, "_lo"}, out_low, last_lo);
    @(posedge clk); #1;
    chk({tag, "_done_next"}, {31'd0, done}, 32'd0);
    chk({tag, "_hi_next"}, out_high, last_hi);
    chk({tag, "_lo_next"}, out_low, last_lo);
    $display("op %s: %h / 0 -> div_zero=%0b lo=%h hi=%h", tag, a, div_zero, out_low, out_high);
  endtask

  initial begin
    logic [31:0] a, b;
    bit quiet;

    #2 reset = 1'b1;
    #1;
    chk("rst_hi", out_high, 32'd0);
    chk("rst_lo", out_low, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(32'd100, 32'd7, 1'b0, "u100_7");
    chk("u100_7_lo_const", out_low, 32'd14);
    chk("u100_7_hi_const", out_high, 32'd2);
    run_op(-32'sd7, 32'd2, 1'b0, "m7_2");
    chk("m7_2_lo_const", out_low, 32'hFFFF_FFFD);
    chk("m7_2_hi_const", out_high, 32'hFFFF_FFFF);
    run_op(32'd7, -32'sd2, 1'b0, "7_m2");
    chk("7_m2_lo_const", out_low, 32'hFFFF_FFFD);
    chk("7_m2_hi_const", out_high, 32'h0000_0001);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf");
    chk("ovf_lo_const", out_low, 32'h8000_0000);
    chk("ovf_hi_const", out_high, 32'h0000_0000);
    run_op(32'd0, 32'd5, 1'b0, "zero_num");
    run_op(32'd95, 32'd10, 1'b0, "q9_r5");
    chk("q9_r5_lo_const", out_low, 32'd9);
    chk("q9_r5_hi_const", out_high, 32'd5);
    run_zero($urandom, "divz");
    run_op(32'd50, 32'd7, 1'b0, "after_dz");

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = 32'($signed($urandom_range(0, 40)) - 20);
        2: begin
          a = 32'($signed($urandom_range(0, 2000)) - 1000);
          b = 32'($signed($urandom_range(0, 40)) - 20);
        end
        default: b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
      endcase
      if (b == 32'd0) b = 32'd3;
      run_op(a, b, 1'b0, $sformatf("rnd%0d", i));
    end

    // Abort: reset at E10 must clear everything without a clock edge.
    dividend = 32'd12345;
    divisor  = 32'd17;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", out_high, 32'd0);
    chk("abort_lo", out_low, 32'd0);
    chk("abort_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 1'b0;
    end
    chk("abort_no_done", {31'd0, quiet}, 32'd1);
    chk("abort_hi_hold", out_high, 32'd0);

    run_op(-32'sd1000, 32'd33, 1'b0, "post_reset");

    // Start held through busy, then reused in the done cycle for a second op.
    run_op(32'd77777, -32'sd123, 1'b1, "b2b_a");
    run_op(-32'sd99999, 32'd321, 1'b0, "b2b_b");
    run_op($urandom, 32'd9, 1'b1, "b2b_c");
    run_op($urandom, -32'sd5, 1'b0, "b2b_d");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
